// File: rtl/usart_tx_if.sv
// Byte handshake between a producer and the usart_tx transmitter.
// The producer drives data_in/valid; the transmitter answers with ready.
interface usart_tx_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/usart_tx.sv
// usart_tx: 8N1 serial transmitter with CTS flow control.
// A byte handed over on the handshake is buffered, then serialised as
// start(0), 8 data bits LSB first, stop(1), each bit clocks_per_bit cycles.
// Optional feature macro USART_TX_FIFO_EN: the buffer becomes a
// 2^FIFO_DEPTH_LOG2-entry FIFO; otherwise it is a single holding register.
// tx_pin is registered and lags the state register by one cycle.
module usart_tx #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        serial_clock,
    input  logic        reset,
    input  logic [11:0] clocks_per_bit,
    usart_tx_if.slave   bus,
    output logic        busy,
    output logic        tx_pin,
    input  logic        cts_pin
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BIT  = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t      state = IDLE;
    state_t      state_next;

    logic [11:0] n_latched  = 12'd1;
    logic [11:0] period_cnt = '0;
    logic [2:0]  bit_cnt    = '0;
    logic [7:0]  shift_reg  = '0;
    logic        tx_reg     = 1'b1;
    logic        tx_next;
    logic        rst_hold   = 1'b1;

    logic [11:0] n_eff;
    logic        bit_end;
    logic        last_data;

    logic        buf_empty;
    logic        buf_full;
    logic [7:0]  buf_data;
    logic        push;
    logic        pop;

    // A zero period is treated as one cycle per bit.
    assign n_eff     = (clocks_per_bit == 12'd0) ? 12'd1 : clocks_per_bit;
    assign bit_end   = (period_cnt == n_latched - 12'd1);
    assign last_data = (bit_cnt == 3'd7);

    // rst_hold keeps ready low on every edge that sees reset, so ready only
    // rises on the first edge after reset is released.
    assign bus.ready = !buf_full && !rst_hold;
    assign push      = bus.valid && bus.ready;
    assign pop       = (state == IDLE) && !buf_empty && !cts_pin;
    assign busy      = (state != IDLE) || !buf_empty;
    assign tx_pin    = tx_reg;

    // Track whether the previous edge saw reset.
    always_ff @(posedge serial_clock) begin
        rst_hold <= reset;
    end

`ifdef USART_TX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE = 1;
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_MAX = DEPTH;

    logic [7:0]                 fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr = '0;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr = '0;
    logic [FIFO_DEPTH_LOG2:0]   count  = '0;

    assign buf_empty = (count == '0);
    assign buf_full  = (count == CNT_MAX);
    assign buf_data  = fifo_mem[rd_ptr];

    // FIFO storage write.
    // NOTE: the storage array has no reset; flushing only needs the pointers
    // and count cleared, and stale entries are never read while count is zero.
    always_ff @(posedge serial_clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.data_in;
        end
    end

    // FIFO pointers and occupancy; push and pop together keep count unchanged.
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0]  hold_data  = '0;
    logic        hold_valid = 1'b0;
    logic [31:0] unused_depth;

    // The depth parameter only sizes the FIFO build.
    assign unused_depth = FIFO_DEPTH_LOG2;

    assign buf_empty = !hold_valid;
    assign buf_full  = hold_valid;
    assign buf_data  = hold_data;

    // Single holding register; push needs it empty and pop needs it full,
    // so the two never coincide.
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_data  <= bus.data_in;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic: CTS is only consulted in IDLE via pop.
    // NOTE: state_next is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (pop)                  state_next = START_BIT;
            START_BIT: if (bit_end)              state_next = DATA_BIT;
            DATA_BIT:  if (bit_end && last_data) state_next = STOP_BIT;
            STOP_BIT:  if (bit_end)              state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // FSM output logic: line level for the current state.
    always_comb begin
        tx_next = 1'b1;
        unique case (state)
            IDLE:      tx_next = 1'b1;
            START_BIT: tx_next = 1'b0;
            DATA_BIT:  tx_next = shift_reg[0];
            STOP_BIT:  tx_next = 1'b1;
            default:   tx_next = 1'b1;
        endcase
    end

    // Bit timing, data shifting and the registered line driver.
    always_ff @(posedge serial_clock) begin
        if (reset) begin
            n_latched  <= 12'd1;
            period_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
        end else begin
            tx_reg <= tx_next;
            if (state == IDLE) begin
                period_cnt <= '0;
                bit_cnt    <= '0;
                if (pop) begin
                    shift_reg <= buf_data;
                    n_latched <= n_eff;
                end
            end else if (bit_end) begin
                period_cnt <= '0;
                if (state == DATA_BIT) begin
                    shift_reg <= {1'b0, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                end
            end else begin
                period_cnt <= period_cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_usart_tx.sv
// Self-checking bench for usart_tx. A scoreboard queue records every byte
// the handshake accepts; each frame on tx_pin is compared cycle by cycle
// against the 8N1 waveform built from that byte and the bit period.
module tb_usart_tx;

`ifdef USART_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic        serial_clock = 1'b0;
    logic        reset        = 1'b1;
    logic [11:0] clocks_per_bit;
    logic        busy;
    logic        tx_pin;
    logic        cts_pin;

    usart_tx_if bus ();

    usart_tx dut (
        .serial_clock   (serial_clock),
        .reset          (reset),
        .clocks_per_bit (clocks_per_bit),
        .bus            (bus),
        .busy           (busy),
        .tx_pin         (tx_pin),
        .cts_pin        (cts_pin)
    );

    always #5 serial_clock = ~serial_clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pend[$];
    logic [7:0] exp_q[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record an accepted byte at the rising edge, then drive the
    // next pending byte (if any) at the falling edge.
    task automatic step();
        bit acc;
        acc = (bus.valid === 1'b1) && (bus.ready === 1'b1) && (reset === 1'b0);
        @(posedge serial_clock);
        if (acc) exp_q.push_back(pend.pop_front());
        @(negedge serial_clock);
        if (pend.size() > 0) begin
            bus.valid   = 1'b1;
            bus.data_in = pend[0];
        end else begin
            bus.valid   = 1'b0;
            bus.data_in = 8'($urandom);
        end
    endtask

    task automatic enqueue(input logic [7:0] b);
        pend.push_back(b);
        if (bus.valid !== 1'b1) begin
            bus.valid   = 1'b1;
            bus.data_in = pend[0];
        end
    endtask

    // Wait (bounded) for the start bit, then compare every cycle of the frame
    // with the expected 8N1 waveform for the oldest accepted byte.
    task automatic expect_frame(input int n, input int max_wait, input int chg_at,
                                input logic [11:0] chg_val, output int waited);
        logic [7:0] b;
        logic       lvl;
        int         idx;
        waited = 0;
        while (tx_pin !== 1'b0 && waited < max_wait) begin
            step();
            waited++;
        end
        check("start_seen", 32'(tx_pin), 32'd0);
        if (tx_pin !== 1'b0) return;
        if (exp_q.size() > 0) b = exp_q.pop_front();
        else b = 8'hxx;
        idx = 0;
        for (int bit_i = 0; bit_i < 10; bit_i++) begin
            if (bit_i == 0)      lvl = 1'b0;
            else if (bit_i == 9) lvl = 1'b1;
            else                 lvl = b[bit_i-1];
            for (int c = 0; c < n; c++) begin
                if (idx == chg_at) clocks_per_bit = chg_val;
                check($sformatf("frame_%02h_bit%0d_cyc%0d", b, bit_i, c), 32'(tx_pin), 32'(lvl));
                step();
                idx++;
            end
        end
    endtask

    initial begin
        int w;
        int nr;
        int eff;
        bus.valid      = 1'b0;
        bus.data_in    = 8'h00;
        cts_pin        = 1'b0;
        clocks_per_bit = 12'd16;

        // Reset state.
        repeat (3) step();
        check("rst_tx", 32'(tx_pin), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        reset = 1'b0;
        check("ready_before_release_edge", 32'(bus.ready), 32'd0);
        step();
        check("ready_after_release", 32'(bus.ready), 32'd1);

        // 0xA5 at N=16, latency two edges.
        enqueue(8'hA5);
        step();
        check("busy_after_accept", 32'(busy), 32'd1);
        expect_frame(16, 10, -1, 12'd0, w);
        check("latency_a5", 32'(w), 32'd2);
        check("idle_tx_a5", 32'(tx_pin), 32'd1);
        check("idle_busy_a5", 32'(busy), 32'd0);

        // Back-to-back 0x00 then 0xFF at N=1.
        clocks_per_bit = 12'd1;
        enqueue(8'h00);
        enqueue(8'hFF);
        step();
        expect_frame(1, 10, -1, 12'd0, w);
        check("latency_00", 32'(w), 32'd2);
        expect_frame(1, 5, -1, 12'd0, w);
        check("gap_ff", 32'(w), 32'd1);
        check("busy_after_ff", 32'(busy), 32'd0);
        check("tx_after_ff", 32'(tx_pin), 32'd1);

        // Period changed mid-frame: current frame keeps 16, next uses 4.
        clocks_per_bit = 12'd16;
        enqueue(8'($urandom));
        enqueue(8'($urandom));
        step();
        expect_frame(16, 10, 40, 12'd4, w);
        check("latency_chg", 32'(w), 32'd2);
        expect_frame(4, 5, -1, 12'd0, w);
        check("gap_chg", 32'(w), 32'd1);

        // N=0 behaves as N=1.
        clocks_per_bit = 12'd0;
        enqueue(8'h55);
        step();
        expect_frame(1, 10, -1, 12'd0, w);
        check("latency_n0", 32'(w), 32'd2);
        check("busy_after_n0", 32'(busy), 32'd0);

        // Random bytes and periods, back-to-back pairs.
        for (int i = 0; i < 4; i++) begin
            nr  = $urandom_range(0, 6);
            eff = (nr == 0) ? 1 : nr;
            clocks_per_bit = 12'(nr);
            enqueue(8'($urandom));
            enqueue(8'($urandom));
            step();
            expect_frame(eff, 10, -1, 12'd0, w);
            check($sformatf("latency_rand%0d", i), 32'(w), 32'd2);
            expect_frame(eff, 5, -1, 12'd0, w);
            check($sformatf("gap_rand%0d", i), 32'(w), 32'd1);
            check($sformatf("busy_rand%0d", i), 32'(busy), 32'd0);
        end

        // CTS held off: buffer fills, line stays idle; release sends in order.
        clocks_per_bit = 12'd2;
        cts_pin = 1'b1;
        for (int i = 0; i < CAP + 2; i++) enqueue(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("cts_idle_cyc%0d", i), 32'(tx_pin), 32'd1);
        end
        check("cts_accepted", 32'(exp_q.size()), 32'(CAP));
        check("cts_ready_full", 32'(bus.ready), 32'd0);
        check("cts_busy", 32'(busy), 32'd1);
        cts_pin = 1'b0;
        for (int i = 0; i < CAP + 2; i++) begin
            expect_frame(2, 30, -1, 12'd0, w);
        end
        step();
        check("cts_drained_busy", 32'(busy), 32'd0);
        check("cts_drained_pend", 32'(pend.size() + exp_q.size()), 32'd0);

        // Reset during data bit 3 at N=8 aborts the frame.
        clocks_per_bit = 12'd8;
        enqueue(8'($urandom));
        step();
        w = 0;
        while (tx_pin !== 1'b0 && w < 10) begin
            step();
            w++;
        end
        check("abort_start_seen", 32'(tx_pin), 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (36) step();
        reset = 1'b1;
        step();
        check("abort_tx", 32'(tx_pin), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(bus.ready), 32'd0);
        reset = 1'b0;
        step();
        check("abort_ready_release", 32'(bus.ready), 32'd1);
        for (int i = 0; i < 30; i++) begin
            check($sformatf("abort_quiet_cyc%0d", i), 32'(tx_pin), 32'd1);
            step();
        end
        enqueue(8'h3C);
        step();
        expect_frame(8, 10, -1, 12'd0, w);
        check("latency_3c", 32'(w), 32'd2);
        check("busy_after_3c", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usart_tx.md
USART_TX -- requirements
Module: usart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH_LOG2, default 2, log2 of the transmit FIFO depth; used only when USART_TX_FIFO_EN is defined.
REQ-002 SHALL have port serial_clock  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port clocks_per_bit  input  12  bit period in serial_clock cycles.
REQ-005 SHALL have port data_in  input  8  byte to transmit.
REQ-006 SHALL have port valid  input  1  data_in is valid.
REQ-007 SHALL have port ready  output  1  block can accept a byte.
REQ-008 SHALL have port busy  output  1  frame in progress or byte buffered.
REQ-009 SHALL have port tx_pin  output  1  serial line, idle high.
REQ-010 SHALL have port cts_pin  input  1  clear-to-send, active-low; peer drives it from its rts_pin.

Function
REQ-011 SHALL transfer a byte into the buffer on a rising edge where valid=1 and ready=1; valid with ready=0 has no effect.
REQ-012 SHALL use frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-013 SHALL hold each bit for N serial_clock cycles, N = clocks_per_bit, with N = 0 treated as 1.
REQ-014 SHALL latch clocks_per_bit at frame start; changes mid-frame SHALL NOT affect the current frame.
REQ-015 SHALL use 12-bit period counter and 3-bit data bit counter, with no wrap or truncation for N up to 4095.
REQ-016 SHALL implement states IDLE, START_BIT, DATA_BIT, STOP_BIT.
REQ-017 In IDLE, SHALL move to START_BIT and pop one buffered byte into the shift register when buffer non-empty and cts_pin=0; otherwise SHALL remain in IDLE with tx_pin=1.
REQ-018 SHALL hold START_BIT for N cycles, then DATA_BIT.
REQ-019 SHALL hold DATA_BIT for 8xN cycles, then STOP_BIT.
REQ-020 SHALL hold STOP_BIT for N cycles, then IDLE.
REQ-021 SHALL sample cts_pin only in IDLE; a started frame SHALL complete regardless of cts_pin.
REQ-022 Latency: byte accepted at edge k into an empty idle block with cts_pin=0 SHALL drive tx_pin low after edge k+2.
REQ-023 Back-to-back: if buffer non-empty and cts_pin=0 when STOP_BIT ends, next start bit SHALL follow after exactly one IDLE cycle, giving frame pitch 10xN+1 cycles.
REQ-024 SHALL drive tx_pin from a register, glitch-free.
REQ-025 SHALL set busy=1 when state is not IDLE or the buffer is non-empty.
REQ-026 SHALL derive ready combinationally from buffer occupancy only, not from valid.
REQ-027 With the buffer full, SHALL hold ready=0 even on a cycle where IDLE pops a byte.

Reset
REQ-028 While reset=1 at an edge, SHALL enter IDLE, flush the buffer, and clear counters and shift register.
REQ-029 While reset=1 at an edge, SHALL set tx_pin=1, busy=0, ready=0.
REQ-030 SHALL set ready=1 on the first edge after reset deasserts.
REQ-031 Reset mid-frame SHALL abort the frame: tx_pin=1 after that edge, and the partial byte is lost.
REQ-032 Power-up register values SHALL equal the reset values.

Configuration
REQ-033 With USART_TX_FIFO_EN defined, the buffer SHALL be a 2^FIFO_DEPTH_LOG2-entry FIFO, order preserved.
REQ-034 With USART_TX_FIFO_EN defined, ready SHALL equal not-full, and simultaneous push and pop when not full SHALL leave occupancy unchanged.
REQ-035 Without USART_TX_FIFO_EN, the buffer SHALL be a single holding register, ready SHALL equal holding-register-empty, and the shift register SHALL remain separate so one byte can wait during a frame.

Verification
REQ-036 N=16, cts_pin=0, send 0xA5 -> tx_pin: 0,1,0,1,0,0,1,0,1,1, each level 16 cycles, first fall 2 edges after accept.
REQ-037 N=1, send 0x00 then 0xFF back-to-back -> frames of 10 cycles separated by one idle-high cycle; busy low after second stop.
REQ-038 cts_pin=1, push bytes until ready=0 -> 4 accepted (FIFO_EN, depth 4) or 1 accepted (no FIFO) and tx_pin stays 1; then cts_pin=0 -> all bytes sent in order.
REQ-039 N=8, reset asserted during DATA_BIT bit 3 -> tx_pin=1 next edge, busy=0, no further frame; next accepted byte 0x3C sent correctly.
REQ-040 N changed from 16 to 4 mid-frame -> current frame keeps 16-cycle bits; next frame uses 4.
REQ-041 N=0, send 0x55 -> identical waveform to N=1.
